// File: rtl/load_store_unit_if.sv
// Signal bundle between the CPU datapath, the load/store unit and the data RAM.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_write_byte_enable;
    logic [31:0] mem_rd;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_we, mem_a, mem_wd, mem_write_byte_enable
    );

    // Environment side: the requesting datapath plus the RAM read port.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_we, mem_a, mem_wd, mem_write_byte_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word accesses at arbitrary byte addresses
// into one or two word-aligned RAM accesses, with lane masking on stores and
// sign/zero extension on loads.
module load_store_unit #(
    parameter bit MISALIGNED_TRAP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    state_t      state_nxt;

    // Latched request and captured read words.
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rd0_q;
    logic [31:0] rd1_q;

    logic        accept;
    logic        req_bad;
    logic [1:0]  off_q;
    logic        crossing_q;
    logic [7:0]  mask8;
    logic [63:0] wd64;
    logic [31:0] rd_win;
    logic [31:0] word_a;

    // Access width in bytes; the illegal encoding never reaches a memory access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when the access spills past the end of its first word.
    function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] end_byte;
        end_byte = {2'b00, off} + {1'b0, size_bytes(size)};
        return end_byte > 4'd4;
    endfunction

    // Byte-lane mask across the two consecutive words touched by the access.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    // Sign- or zero-extend the low bytes of a right-justified load value.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b01:   return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign accept     = (state == IDLE) && bus.req_valid;
    assign req_bad    = (bus.req_size == 2'b11) ||
                        (MISALIGNED_TRAP && crosses(bus.req_size, bus.req_addr[1:0]));
    assign off_q      = addr_q[1:0];
    assign crossing_q = crosses(size_q, off_q);
    assign mask8      = lane_mask(size_q, off_q);
    assign wd64       = {32'b0, wdata_q} << {off_q, 3'b000};
    assign rd_win     = 32'({rd1_q, rd0_q} >> {off_q, 3'b000});
    assign word_a     = {addr_q[31:2], 2'b00};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the request on acceptance and capture RAM words during load accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            err_q   <= 1'b0;
            rd0_q   <= 32'b0;
            rd1_q   <= 32'b0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= req_bad;
                rd0_q   <= 32'b0;
                rd1_q   <= 32'b0;
            end
            if (state == ACC0 && !wr_q) rd0_q <= bus.mem_rd;
            if (state == ACC1 && !wr_q) rd1_q <= bus.mem_rd;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_bad ? RESP : ACC0;
            ACC0: state_nxt = crossing_q ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs; everything idles at zero outside its owning state.
    always_comb begin
        bus.req_ready             = (state == IDLE);
        bus.mem_we                = 1'b0;
        bus.mem_a                 = 32'b0;
        bus.mem_wd                = 32'b0;
        bus.mem_write_byte_enable = 4'b0;
        bus.resp_valid            = 1'b0;
        bus.resp_error            = 1'b0;
        bus.resp_rdata            = 32'b0;
        case (state)
            ACC0: begin
                bus.mem_we                = wr_q;
                bus.mem_a                 = word_a;
                bus.mem_write_byte_enable = mask8[3:0];
                bus.mem_wd                = wd64[31:0];
            end
            ACC1: begin
                bus.mem_we                = wr_q;
                bus.mem_a                 = word_a + 32'd4;
                bus.mem_write_byte_enable = mask8[7:4];
                bus.mem_wd                = wd64[63:32];
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err_q;
                bus.resp_rdata = (!wr_q && !err_q) ? extend(rd_win, size_q, uns_q) : 32'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one split-mode and one trap-mode instance, each
// with its own byte-lane RAM, checked against a byte-array memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    logic ram_clear;
    always #5 clk = ~clk;

    load_store_unit_if bus0();
    load_store_unit_if bus1();

    load_store_unit #(.MISALIGNED_TRAP(1'b0)) u_split (.clk(clk), .rst(rst), .bus(bus0));
    load_store_unit #(.MISALIGNED_TRAP(1'b1)) u_trap  (.clk(clk), .rst(rst), .bus(bus1));

    // Shared request drive; t_sel picks which instance sees req_valid.
    logic        t_sel;
    logic        t_valid;
    logic        t_write;
    logic [1:0]  t_size;
    logic        t_uns;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;

    assign bus0.req_valid    = t_valid & ~t_sel;
    assign bus1.req_valid    = t_valid &  t_sel;
    assign bus0.req_write    = t_write;
    assign bus1.req_write    = t_write;
    assign bus0.req_size     = t_size;
    assign bus1.req_size     = t_size;
    assign bus0.req_unsigned = t_uns;
    assign bus1.req_unsigned = t_uns;
    assign bus0.req_addr     = t_addr;
    assign bus1.req_addr     = t_addr;
    assign bus0.req_wdata    = t_wdata;
    assign bus1.req_wdata    = t_wdata;

    // 1 KiB RAMs, combinational read, masked synchronous write.
    logic [31:0] ram0 [0:255];
    logic [31:0] ram1 [0:255];
    assign bus0.mem_rd = ram0[bus0.mem_a[9:2]];
    assign bus1.mem_rd = ram1[bus1.mem_a[9:2]];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= 32'b0;
                ram1[i] <= 32'b0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus0.mem_we && bus0.mem_write_byte_enable[b])
                    ram0[bus0.mem_a[9:2]][8*b +: 8] <= bus0.mem_wd[8*b +: 8];
                if (bus1.mem_we && bus1.mem_write_byte_enable[b])
                    ram1[bus1.mem_a[9:2]][8*b +: 8] <= bus1.mem_wd[8*b +: 8];
            end
        end
    end

    // Observed signals of the selected instance.
    wire        obs_ready = t_sel ? bus1.req_ready  : bus0.req_ready;
    wire        obs_valid = t_sel ? bus1.resp_valid : bus0.resp_valid;
    wire        obs_err   = t_sel ? bus1.resp_error : bus0.resp_error;
    wire [31:0] obs_rdata = t_sel ? bus1.resp_rdata : bus0.resp_rdata;
    wire        obs_we    = t_sel ? bus1.mem_we     : bus0.mem_we;
    wire [31:0] obs_a     = t_sel ? bus1.mem_a      : bus0.mem_a;
    wire [31:0] obs_wd    = t_sel ? bus1.mem_wd     : bus0.mem_wd;
    wire [3:0]  obs_be    = t_sel ? bus1.mem_write_byte_enable : bus0.mem_write_byte_enable;

    int checks = 0;
    int errors = 0;

    // Reference memory: plain bytes, address taken modulo 1 KiB like the RAMs.
    logic [7:0] ref_mem [0:1][0:1023];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_cross(input logic [31:0] addr, input logic [1:0] sz);
        return (int'(addr[1:0]) + nbytes(sz)) > 4;
    endfunction

    task automatic ref_store(input bit sel, input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] wd);
        logic [31:0] a;
        for (int i = 0; i < nbytes(sz); i++) begin
            a = addr + 32'(i);
            ref_mem[sel][a[9:0]] = wd[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] ref_load(input bit sel, input logic [31:0] addr,
                                             input logic [1:0] sz, input bit uns);
        int          n;
        logic [63:0] v;
        logic [31:0] a;
        n = nbytes(sz);
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (64'(ref_mem[sel][a[9:0]]) << (8*i));
        end
        if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    // Per-cycle snapshot of the memory port after acceptance (index = cycles after accept).
    logic [31:0] cap_a  [1:3];
    logic [3:0]  cap_be [1:3];
    logic [31:0] cap_wd [1:3];
    logic        cap_we [1:3];
    logic        any_we;

    // Issue one request, wait (bounded) for resp_valid; lat = -1 if none arrives.
    task automatic do_req(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output bit err, output int lat);
        @(negedge clk);
        t_sel = sel; t_write = wr; t_size = sz; t_uns = uns; t_addr = addr; t_wdata = wd;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = -1; rdata = 32'b0; err = 1'b0; any_we = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                cap_a[c] = obs_a; cap_be[c] = obs_be; cap_wd[c] = obs_wd; cap_we[c] = obs_we;
            end
            if (obs_we) any_we = 1'b1;
            if (obs_valid) begin
                lat = c; rdata = obs_rdata; err = obs_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_clear = 1'b1; t_valid = 1'b0; t_sel = 1'b0;
        t_write = 1'b0; t_size = 2'b0; t_uns = 1'b0; t_addr = 32'b0; t_wdata = 32'b0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) ref_mem[s][i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", bus0.req_ready); end
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b expected 1", bus1.req_ready); end
        checks++; if (bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus0.resp_valid); end
        checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus0.mem_we); end
        checks++; if (bus0.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", bus0.mem_a); end
        checks++; if (bus0.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus0.resp_rdata); end
        rst = 1'b0; ram_clear = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; bit er; int lat;
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, rd, er, lat);
        ref_store(1'b0, 32'h10, 2'd2, 32'h12345678);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat: got %0d expected 2", lat); end
        checks++; if (cap_a[1] !== 32'h10) begin errors++; $display("FAIL word_store_a: got %h expected 00000010", cap_a[1]); end
        checks++; if (cap_be[1] !== 4'b1111) begin errors++; $display("FAIL word_store_be: got %b expected 1111", cap_be[1]); end
        checks++; if (cap_wd[1] !== 32'h12345678) begin errors++; $display("FAIL word_store_wd: got %h expected 12345678", cap_wd[1]); end
        checks++; if (cap_we[1] !== 1'b1) begin errors++; $display("FAIL word_store_we: got %b expected 1", cap_we[1]); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL word_store_resp: got %h/%b expected 0/0", rd, er); end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL word_load: got %h expected 12345678", rd); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; bit er; int lat;
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, rd, er, lat);
        ref_store(1'b0, 32'h13, 2'd0, 32'h000000AB);
        checks++; if (cap_be[1] !== 4'b1000) begin errors++; $display("FAIL byte_store_be: got %b expected 1000", cap_be[1]); end
        checks++; if (cap_wd[1] !== 32'hAB000000) begin errors++; $display("FAIL byte_store_wd: got %h expected ab000000", cap_wd[1]); end
        do_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_load_signed: got %h expected ffffffab", rd); end
        do_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL byte_load_unsigned: got %h expected 000000ab", rd); end
    endtask

    task automatic test_cross();
        logic [31:0] rd; bit er; int lat;
        do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h07, 32'h0000BEEF, rd, er, lat);
        ref_store(1'b0, 32'h07, 2'd1, 32'h0000BEEF);
        checks++; if (lat !== 3) begin errors++; $display("FAIL cross_store_lat: got %0d expected 3", lat); end
        checks++; if (cap_a[1] !== 32'h4 || cap_be[1] !== 4'b1000 || cap_wd[1] !== 32'hEF000000) begin
            errors++; $display("FAIL cross_acc0: got a=%h be=%b wd=%h expected a=00000004 be=1000 wd=ef000000", cap_a[1], cap_be[1], cap_wd[1]); end
        checks++; if (cap_a[2] !== 32'h8 || cap_be[2] !== 4'b0001 || cap_wd[2] !== 32'h000000BE) begin
            errors++; $display("FAIL cross_acc1: got a=%h be=%b wd=%h expected a=00000008 be=0001 wd=000000be", cap_a[2], cap_be[2], cap_wd[2]); end
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h07, 32'h0, rd, er, lat);
        checks++; if (lat !== 3 || rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL cross_load: got %h lat %0d expected ffffbeef lat 3", rd, lat); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; bit er; int lat;
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h11223344, rd, er, lat);
        ref_store(1'b0, 32'hFFFFFFFC, 2'd2, 32'h11223344);
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h00000000, 32'h55667788, rd, er, lat);
        ref_store(1'b0, 32'h00000000, 2'd2, 32'h55667788);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, rd, er, lat);
        checks++; if (cap_a[1] !== 32'hFFFFFFFC || cap_a[2] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr: got %h,%h expected fffffffc,00000000", cap_a[1], cap_a[2]); end
        checks++; if (lat !== 3 || rd !== 32'h77881122) begin errors++; $display("FAIL wrap_load: got %h lat %0d expected 77881122 lat 3", rd, lat); end
    endtask

    task automatic test_trap();
        logic [31:0] rd; bit er; int lat;
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h05, 32'h0, rd, er, lat);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL trap_misaligned: got err=%b rd=%h lat=%0d expected err=1 rd=0 lat=1", er, rd, lat); end
        checks++; if (any_we !== 1'b0) begin errors++; $display("FAIL trap_no_write: got %b expected 0", any_we); end
        do_req(1'b1, 1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || any_we !== 1'b0) begin
            errors++; $display("FAIL trap_illegal: got err=%b rd=%h lat=%0d we=%b expected 1/0/1/0", er, rd, lat, any_we); end
        do_req(1'b0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL split_illegal: got err=%b rd=%h lat=%0d expected err=1 rd=0 lat=1", er, rd, lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit er; int lat; bit saw_resp;
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'hA1A2A3A4, rd, er, lat);
        ref_store(1'b0, 32'h04, 2'd2, 32'hA1A2A3A4);
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'hB1B2B3B4, rd, er, lat);
        ref_store(1'b0, 32'h08, 2'd2, 32'hB1B2B3B4);
        saw_resp = 1'b0;
        @(negedge clk);
        t_sel = 1'b0; t_write = 1'b1; t_size = 2'd1; t_uns = 1'b0; t_addr = 32'h07; t_wdata = 32'h0000BEEF;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        if (bus0.resp_valid) saw_resp = 1'b1;
        @(negedge clk);
        checks++; if (bus0.mem_we !== 1'b1 || bus0.mem_a !== 32'h8) begin
            errors++; $display("FAIL midreset_acc1: got we=%b a=%h expected we=1 a=00000008", bus0.mem_we, bus0.mem_a); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.mem_we !== 1'b0 || bus0.req_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_async: got we=%b ready=%b expected we=0 ready=1", bus0.mem_we, bus0.req_ready); end
        ref_mem[0][7] = 8'hEF;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus0.resp_valid) saw_resp = 1'b1;
        end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL midreset_no_resp: got %b expected 0", saw_resp); end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, er, lat);
        checks++; if (lat !== 2 || rd !== 32'hEFA2A3A4 || rd !== ref_load(1'b0, 32'h04, 2'd2, 1'b0)) begin
            errors++; $display("FAIL midreset_word4: got %h lat %0d expected efa2a3a4 lat 2", rd, lat); end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, er, lat);
        checks++; if (rd !== ref_load(1'b0, 32'h08, 2'd2, 1'b0)) begin
            errors++; $display("FAIL midreset_word8: got %h expected %h", rd, ref_load(1'b0, 32'h08, 2'd2, 1'b0)); end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] rd, addr, wd, exp_rd; bit er, sel, wr, uns, exp_err; int lat, exp_lat, r;
        logic [1:0] sz;
        for (int it = 0; it < 80; it++) begin
            sel  = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            sz   = (r == 9) ? 2'd3 : 2'(r % 3);
            addr = 32'($urandom_range(0, 1023));
            wd   = $urandom;
            exp_err = (sz == 2'd3) || (sel && ref_cross(addr, sz));
            exp_lat = exp_err ? 1 : (ref_cross(addr, sz) ? 3 : 2);
            exp_rd  = (exp_err || wr) ? 32'h0 : ref_load(sel, addr, sz, uns);
            do_req(sel, wr, sz, uns, addr, wd, rd, er, lat);
            if (!exp_err && wr) ref_store(sel, addr, sz, wd);
            checks++; if (lat !== exp_lat || er !== exp_err || rd !== exp_rd) begin
                errors++;
                $display("FAIL rand_%0d: sel=%b wr=%b sz=%0d a=%h got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=%0d",
                         it, sel, wr, sz, addr, rd, er, lat, exp_rd, exp_err, exp_lat);
            end
            checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL rand_ready_in_resp_%0d: got %b expected 0", it, obs_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_cross();
        test_wrap();
        test_trap();
        test_reset_mid();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory access stage between the CPU datapath and the word-addressed data RAM. It accepts byte, halfword and word load/store requests at arbitrary byte addresses and converts each into one or two word-aligned RAM accesses. For each access it generates the per-byte write enables and lane-shifted write data, and assembles loaded bytes into a sign- or zero-extended result. The downstream RAM has a combinational read and a synchronous masked write.

## Interface
- MISALIGNED_TRAP, default 0: 0 = split word-crossing accesses into two RAM accesses; 1 = reject them with resp_error.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  misaligned under trap, or illegal size
- mem_we  out  1  RAM write strobe
- mem_a  out  32  RAM byte address, bits [1:0] always 00
- mem_wd  out  32  RAM write data, lane-aligned
- mem_write_byte_enable  out  4  RAM byte-lane mask
- mem_rd  in  32  RAM read word, combinational from mem_a

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: when req_valid and req_ready are both high, latch all req_* fields.
  - Illegal size, or crossing with MISALIGNED_TRAP=1: go to RESP with error set and no memory access.
  - Otherwise go to ACC0.
- Derived values:
  - n = 1, 2 or 4 bytes; off = addr[1:0].
  - crossing = off + n > 4.
  - mask8 = ((1<<n)-1) << off.
  - wd64 = {32'b0, wdata} << (8*off).
- ACC0:
  - mem_a = {addr[31:2], 2'b00}; mem_write_byte_enable = mask8[3:0]; mem_wd = wd64[31:0].
  - mem_we = req_write.
  - Loads capture mem_rd into rd0.
  - Next state: ACC1 if crossing, else RESP.
- ACC1:
  - mem_a = {addr[31:2], 2'b00} + 4, wrapping modulo 2^32.
  - Enables = mask8[7:4]; mem_wd = wd64[63:32]; mem_we = req_write.
  - Loads capture mem_rd into rd1.
  - Next state: RESP.
- RESP:
  - resp_valid = 1.
  - For loads, resp_rdata = low n bytes of ({rd1, rd0} >> 8*off), extended per req_unsigned; otherwise 0.
  - Next state: IDLE.
- Outside ACC0/ACC1: mem_we, mem_a, mem_wd and mem_write_byte_enable are 0.
- Outside RESP: resp_valid, resp_error and resp_rdata are 0.
- Byte lanes not enabled are never modified; the RAM preserves them.

## Timing
- Reset (asynchronous, immediate): state IDLE, req_ready = 1, all other outputs 0, latched request cleared.
- Request accepted at edge k:
  - Aligned access: ACC0 in cycle k+1, resp_valid in cycle k+2.
  - Crossing access: ACC0 in k+1, ACC1 in k+2, resp_valid in k+3.
  - Trapped or illegal request: resp_valid with resp_error in cycle k+1.
- req_ready is low from the cycle after acceptance through RESP. The next request is accepted in the IDLE cycle after RESP.
- Maximum throughput: one aligned access per 3 cycles.
- Stores commit per access on the clock edge that ends ACC0 or ACC1.
- Reset during ACC1 of a crossing store: the first word stays written, the second is never written, and mem_we drops immediately.
- Reset during any state returns to IDLE with no response emitted.
- req_* inputs are ignored in every state except IDLE.

## Test plan
- Store word 0x12345678 at 0x10, then load word at 0x10:
  - Store: ACC0 shows mem_a=0x10, enables 1111, mem_wd=0x12345678.
  - Load: resp_rdata=0x12345678 at accept+2.
- Store byte 0xAB at 0x13: enables 1000, mem_wd=0xAB000000. Follow-up loads from 0x13:
  - Signed byte load: 0xFFFFFFAB.
  - Unsigned byte load: 0x000000AB.
- Store halfword 0xBEEF at 0x07 (MISALIGNED_TRAP=0):
  - ACC0: mem_a=0x04, enables 1000, mem_wd=0xEF000000.
  - ACC1: mem_a=0x08, enables 0001, mem_wd=0x000000BE.
  - Signed halfword load from 0x07: 0xFFFFBEEF at accept+3.
- Load word at 0xFFFFFFFE: ACC1 mem_a=0x00000000. Result = bytes 2-3 of the top word in the low half, bytes 0-1 of word 0 in the high half.
- MISALIGNED_TRAP=1:
  - Load word at 0x05: resp_error=1, resp_rdata=0 at accept+1, mem_we never asserted.
  - req_size=11 gives the same response.
- Halfword store at 0x07 with rst asserted during ACC1:
  - Word 0x04 byte 3 = 0xEF; word 0x08 unchanged.
  - No resp_valid; req_ready=1 during reset.
  - The next request is accepted normally.
